// File: rtl/feeder_pkg.sv
// Shared definitions for the systolic array operand feeder.
// ROWS / COLS : default array geometry (west lanes / north lanes)
// RAM_DEPTH   : operand BRAM depth; ADDR_W is derived from it
// state_e     : feeder FSM states
// clogb2      : ceil(log2(value)), used to size counters
package feeder_pkg;

    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 4;
    localparam int unsigned RAM_DEPTH = 128;

    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int unsigned ADDR_W = clogb2(RAM_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Control and BRAM-side bus of the systolic feeder.
// master : issues start/k_len/base_w/base_n, observes addresses, valids and status
// slave  : the feeder itself
interface systolic_feeder_if #(
    parameter int unsigned ROWS   = feeder_pkg::ROWS,
    parameter int unsigned COLS   = feeder_pkg::COLS,
    parameter int unsigned ADDR_W = feeder_pkg::ADDR_W
);
    logic              start;
    logic [ADDR_W:0]   k_len;
    logic [ADDR_W-1:0] base_w;
    logic [ADDR_W-1:0] base_n;
    logic [ADDR_W-1:0] addrb_w [0:ROWS-1];
    logic [ADDR_W-1:0] addrb_n [0:COLS-1];
    logic [ROWS-1:0]   valid_w;
    logic [COLS-1:0]   valid_n;
    logic              acc_clr;
    logic              busy;
    logic              done;

    modport master (
        output start, k_len, base_w, base_n,
        input  addrb_w, addrb_n, valid_w, valid_n, acc_clr, busy, done
    );

    modport slave (
        input  start, k_len, base_w, base_n,
        output addrb_w, addrb_n, valid_w, valid_n, acc_clr, busy, done
    );
endinterface

// File: rtl/skew_lane.sv
// One skewed operand lane: lane LANE is active for steps LANE .. LANE+K-1 and
// reads base + (step - LANE). The address register is loaded with the step that
// will be current next cycle, so address step t appears in cycle t+1.
// clk_i, rst_ni : clock, async active-low reset
// run_i         : next-cycle FSM state is RUN
// step_i        : next-cycle step counter
// k_len_i       : latched (clamped) inner dimension
// base_i        : latched operand base address
// addr_o        : BRAM read address (held while inactive)
// valid_o       : lane-active flag delayed by the BRAM read latency
module skew_lane #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned T_W    = 9,
    parameter int unsigned LANE   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [T_W-1:0]    step_i,
    input  logic [ADDR_W:0]   k_len_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o
);
    localparam logic [T_W-1:0] OFFSET = T_W'(LANE);

    logic [T_W-1:0]    rel;
    logic              active_d, active_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              valid_q;

    always_comb begin
        rel      = step_i - OFFSET;
        // rel < K together with step >= LANE is LANE <= step < LANE+K
        active_d = run_i && (step_i >= OFFSET) && (rel < T_W'(k_len_i));
        // truncation gives the modulo-2^ADDR_W wrap
        addr_d   = active_d ? (base_i + rel[ADDR_W-1:0]) : addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
            valid_q  <= active_q;
        end
    end

    assign addr_o  = addr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/systolic_feeder.sv
// Feeds a ROWS x COLS systolic array from operand BRAMs with the diagonal skew
// the array needs, then waits for the last operands to drain through.
// clk : clock (rising edge)
// rst : async active-low reset
// bus : slave side of systolic_feeder_if (start/k_len/bases in, addresses,
//       valid masks, acc_clr, busy, done out)
module systolic_feeder
    import feeder_pkg::state_e;
    import feeder_pkg::StIdle;
    import feeder_pkg::StRun;
    import feeder_pkg::StDrain;
    import feeder_pkg::StFin;
    import feeder_pkg::clogb2;
#(
    parameter int unsigned ROWS   = feeder_pkg::ROWS,
    parameter int unsigned COLS   = feeder_pkg::COLS,
    parameter int unsigned ADDR_W = feeder_pkg::ADDR_W
) (
    input logic              clk,
    input logic              rst,
    systolic_feeder_if.slave bus
);
    localparam int unsigned MAX_LANE = (ROWS > COLS) ? ROWS : COLS;
    localparam int unsigned K_MAX    = 1 << ADDR_W;
    localparam int unsigned T_W      = clogb2(K_MAX + ROWS + COLS) + 1;

    localparam logic [ADDR_W:0] K_LIM      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [T_W-1:0]  RUN_EXTRA  = T_W'(MAX_LANE - 1);
    localparam logic [T_W-1:0]  DRAIN_LAST = T_W'(ROWS + COLS - 2);

    state_e            state_d, state_q;
    logic [T_W-1:0]    t_d, t_q;
    logic [ADDR_W:0]   k_d, k_q;
    logic [ADDR_W-1:0] bw_d, bw_q;
    logic [ADDR_W-1:0] bn_d, bn_q;
    logic              acc_clr_d, acc_clr_q;
    logic [ADDR_W:0]   k_clamped;
    logic              run_d;

    assign k_clamped = (bus.k_len > K_LIM) ? K_LIM : bus.k_len;

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        k_d       = k_q;
        bw_d      = bw_q;
        bn_d      = bn_q;
        acc_clr_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    k_d       = k_clamped;
                    bw_d      = bus.base_w;
                    bn_d      = bus.base_n;
                    acc_clr_d = 1'b1;
                    t_d       = '0;
                    state_d   = (k_clamped == '0) ? StFin : StRun;
                end
            end
            StRun: begin
                // RUN covers steps 0 .. K+MAX_LANE-2
                if (t_q + T_W'(1) == T_W'(k_q) + RUN_EXTRA) begin
                    state_d = StDrain;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            StDrain: begin
                if (t_q == DRAIN_LAST) begin
                    state_d = StFin;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            StFin: begin
                // An empty pass lands here while the clear pulse is still out;
                // hold one more cycle so done never coincides with acc_clr.
                if (!acc_clr_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            t_q       <= '0;
            k_q       <= '0;
            bw_q      <= '0;
            bn_q      <= '0;
            acc_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            k_q       <= k_d;
            bw_q      <= bw_d;
            bn_q      <= bn_d;
            acc_clr_q <= acc_clr_d;
        end
    end

    assign run_d       = (state_d == StRun);
    assign bus.acc_clr = acc_clr_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StFin) && !acc_clr_q;

    logic [ROWS-1:0] vw;
    logic [COLS-1:0] vn;

    for (genvar i = 0; i < ROWS; i++) begin : g_west
        logic [ADDR_W-1:0] addr;
        skew_lane #(
            .ADDR_W (ADDR_W),
            .T_W    (T_W),
            .LANE   (i)
        ) u_lane (
            .clk_i   (clk),
            .rst_ni  (rst),
            .run_i   (run_d),
            .step_i  (t_d),
            .k_len_i (k_d),
            .base_i  (bw_d),
            .addr_o  (addr),
            .valid_o (vw[i])
        );
        assign bus.addrb_w[i] = addr;
    end

    for (genvar j = 0; j < COLS; j++) begin : g_north
        logic [ADDR_W-1:0] addr;
        skew_lane #(
            .ADDR_W (ADDR_W),
            .T_W    (T_W),
            .LANE   (j)
        ) u_lane (
            .clk_i   (clk),
            .rst_ni  (rst),
            .run_i   (run_d),
            .step_i  (t_d),
            .k_len_i (k_d),
            .base_i  (bn_d),
            .addr_o  (addr),
            .valid_o (vn[j])
        );
        assign bus.addrb_n[j] = addr;
    end

    assign bus.valid_w = vw;
    assign bus.valid_n = vn;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (4x4, 128-deep RAM).
module tb_systolic_feeder;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned ADDR_W = 7;
    localparam int          MAXL   = 4;
    localparam int          DEPTH  = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) bus ();

    systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model, straight from the pass rules.
    function automatic int clamp_k(input int k);
        return (k > DEPTH) ? DEPTH : k;
    endfunction

    function automatic int done_cycle(input int kc);
        if (kc == 0) return 2;
        return 1 + (kc + MAXL - 1) + (ROWS + COLS - 1);
    endfunction

    // Lane shows step t = c-1 in cycle c when lane <= t < lane+K.
    function automatic bit lane_on(input int kc, input int lane, input int c);
        int t;
        t = c - 1;
        return (t >= lane) && (t < lane + kc);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " busy"}, int'(bus.busy), 0);
        check({tag, " done"}, int'(bus.done), 0);
        check({tag, " acc_clr"}, int'(bus.acc_clr), 0);
        check({tag, " valid_w"}, int'(bus.valid_w), 0);
        check({tag, " valid_n"}, int'(bus.valid_n), 0);
        for (int i = 0; i < ROWS; i++)
            check($sformatf("%s addrb_w[%0d]", tag, i), int'(bus.addrb_w[i]), 0);
        for (int j = 0; j < COLS; j++)
            check($sformatf("%s addrb_n[%0d]", tag, j), int'(bus.addrb_n[j]), 0);
    endtask

    // Called at a negedge with the DUT idle. extra: cycle in which a stray start
    // is held high (-1 none); rst_at: cycle to assert reset and abort (0 none).
    task automatic run_pass(input int k, input int bw, input int bn, input int extra,
                            input int rst_at, output int done_at, output int vtot,
                            output int w3_last);
        int kc, f, ew, en;
        kc = clamp_k(k);
        f  = done_cycle(kc);
        done_at = -1;
        vtot    = 0;
        w3_last = -1;
        bus.k_len  = 8'(k);
        bus.base_w = 7'(bw);
        bus.base_n = 7'(bn);
        bus.start  = 1'b1;
        for (int c = 1; c <= f + 2; c++) begin
            @(negedge clk);
            if (c == rst_at) begin
                bus.start = 1'b0;
                rst = 1'b0;
                #1;
                check_zero($sformatf("midreset c%0d", c));
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            check($sformatf("busy c%0d", c), int'(bus.busy), int'(c <= f));
            check($sformatf("done c%0d", c), int'(bus.done), int'(c == f));
            check($sformatf("acc_clr c%0d", c), int'(bus.acc_clr), int'(c == 1));
            ew = 0;
            en = 0;
            for (int i = 0; i < ROWS; i++) begin
                if (lane_on(kc, i, c - 1)) ew |= (1 << i);
                if (lane_on(kc, i, c))
                    check($sformatf("addrb_w[%0d] c%0d", i, c), int'(bus.addrb_w[i]),
                          (bw + c - 1 - i) % DEPTH);
            end
            for (int j = 0; j < COLS; j++) begin
                if (lane_on(kc, j, c - 1)) en |= (1 << j);
                if (lane_on(kc, j, c))
                    check($sformatf("addrb_n[%0d] c%0d", j, c), int'(bus.addrb_n[j]),
                          (bn + c - 1 - j) % DEPTH);
            end
            check($sformatf("valid_w c%0d", c), int'(bus.valid_w), ew);
            check($sformatf("valid_n c%0d", c), int'(bus.valid_n), en);
            if (bus.done && done_at < 0) done_at = c;
            vtot += $countones(bus.valid_w) + $countones(bus.valid_n);
            if (lane_on(kc, 3, c)) w3_last = int'(bus.addrb_w[3]);
            // Scramble operands so only the latched values can matter.
            bus.start  = (c == extra);
            bus.k_len  = 8'($urandom);
            bus.base_w = 7'($urandom);
            bus.base_n = 7'($urandom);
        end
        bus.start = 1'b0;
    endtask

    typedef struct {
        int k;
        int bw;
        int bn;
        int exp_done;
        int exp_vtot;
        int exp_w3_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d, v, w, k, bw, bn, ex;

        vecs[0] = '{k: 4,   bw: 0,   bn: 16,  exp_done: 15,  exp_vtot: 32,   exp_w3_last: 3};
        vecs[1] = '{k: 4,   bw: 126, bn: 0,   exp_done: 15,  exp_vtot: 32,   exp_w3_last: 1};
        vecs[2] = '{k: 0,   bw: 5,   bn: 5,   exp_done: 2,   exp_vtot: 0,    exp_w3_last: 0};
        vecs[3] = '{k: 200, bw: 10,  bn: 3,   exp_done: 139, exp_vtot: 1024, exp_w3_last: 9};
        vecs[4] = '{k: 1,   bw: 127, bn: 127, exp_done: 12,  exp_vtot: 8,    exp_w3_last: 127};
        vecs[5] = '{k: 128, bw: 0,   bn: 0,   exp_done: 139, exp_vtot: 1024, exp_w3_last: 127};

        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.k_len  = '0;
        bus.base_w = '0;
        bus.base_n = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_zero("idle");

        foreach (vecs[n]) begin
            run_pass(vecs[n].k, vecs[n].bw, vecs[n].bn, -1, 0, d, v, w);
            check($sformatf("vec%0d done cycle", n), d, vecs[n].exp_done);
            check($sformatf("vec%0d valid count", n), v, vecs[n].exp_vtot);
            if (vecs[n].k > 0) check($sformatf("vec%0d w3 last", n), w, vecs[n].exp_w3_last);
        end

        // Stray start in the middle of a pass.
        run_pass(4, 0, 16, 5, 0, d, v, w);
        check("midstart done cycle", d, 15);
        check("midstart valid count", v, 32);

        // Start coinciding with done is dropped; bench sees busy stay low after.
        run_pass(4, 3, 9, 15, 0, d, v, w);
        check("donestart done cycle", d, 15);

        // Reset mid-pass, then a fresh pass.
        run_pass(4, 0, 16, -1, 6, d, v, w);
        run_pass(4, 0, 16, -1, 0, d, v, w);
        check("postreset done cycle", d, 15);
        check("postreset valid count", v, 32);
        check("postreset w3 last", w, 3);

        repeat (20) begin
            k  = $urandom_range(0, 140);
            bw = $urandom_range(0, DEPTH - 1);
            bn = $urandom_range(0, DEPTH - 1);
            ex = ($urandom_range(0, 1) == 1) ? $urandom_range(1, done_cycle(clamp_k(k))) : -1;
            run_pass(k, bw, bn, ex, 0, d, v, w);
            check($sformatf("rand k=%0d done cycle", k), d, done_cycle(clamp_k(k)));
            check($sformatf("rand k=%0d valid count", k), v, clamp_k(k) * (ROWS + COLS));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
